// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: default widths, function codes, FSM encoding.
package alu_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_FUNC_W = 3;
    localparam int unsigned CNT_W      = 16;

    // Only ADD and SUB produce a meaningful carry/borrow; other codes are opaque.
    localparam logic [DEF_FUNC_W-1:0] FUNC_ADD = 3'd0;
    localparam logic [DEF_FUNC_W-1:0] FUNC_SUB = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       pick
);

    always_comb begin
        pick = 1'b0;
        if (valid == 2'b11) begin
            pick = ~last_grant;
        end else if (valid[1]) begin
            pick = 1'b1;
        end
        grant = {pick, ~pick} & {2{|valid}};
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters, one operation in flight.
// Optional per-requester grant counters when ALU_ARB_STATS_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned FUNC_W = DEF_FUNC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,
    input  logic [FUNC_W-1:0] r0_func,
    output logic              r0_resp_valid,
    input  logic              r0_resp_ready,
    output logic [WIDTH-1:0]  r0_result,
    output logic              r0_flag,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,
    input  logic [FUNC_W-1:0] r1_func,
    output logic              r1_resp_valid,
    input  logic              r1_resp_ready,
    output logic [WIDTH-1:0]  r1_result,
    output logic              r1_flag,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_cout,
`ifdef ALU_ARB_STATS_EN
    output logic              busy,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`else
    output logic              busy
`endif
);

    state_e                       state_q, state_d;
    logic                         last_grant_q, last_grant_d;
    logic                         owner_q, owner_d;
    logic [WIDTH-1:0]             alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [FUNC_W-1:0]            alu_func_q, alu_func_d;
    logic [1:0]                   resp_valid_q, resp_valid_d;
    logic [1:0][WIDTH-1:0]        result_q, result_d;
    logic [1:0]                   flag_q, flag_d;
    logic                         busy_q, busy_d;

    logic [1:0]                   req_valid, resp_ready, arb_grant, ready_c;
    logic                         arb_pick, accept_c, func_has_flag;

    assign req_valid  = {r1_valid, r0_valid};
    assign resp_ready = {r1_resp_ready, r0_resp_ready};

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .pick       (arb_pick)
    );

    assign func_has_flag = (alu_func_q == FUNC_W'(FUNC_ADD)) || (alu_func_q == FUNC_W'(FUNC_SUB));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_func_d   = alu_func_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        flag_d       = flag_q;
        ready_c      = 2'b00;
        accept_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    ready_c    = arb_grant;
                    accept_c   = 1'b1;
                    alu_a_d    = arb_pick ? r1_a    : r0_a;
                    alu_b_d    = arb_pick ? r1_b    : r0_b;
                    alu_func_d = arb_pick ? r1_func : r0_func;
                    owner_d    = arb_pick;
                    state_d    = EXEC;
                end
            end
            // ALU output has settled on the registered operands; capture it for the owner.
            EXEC: begin
                result_d[owner_q]     = alu_result;
                flag_d[owner_q]       = alu_cout & func_has_flag;
                resp_valid_d[owner_q] = 1'b1;
                last_grant_d          = owner_q;
                state_d               = RESP;
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    resp_valid_d[owner_q] = 1'b0;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_func_q   <= '0;
            resp_valid_q <= '0;
            result_q     <= '0;
            flag_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_func_q   <= alu_func_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            flag_q       <= flag_d;
            busy_q       <= busy_d;
        end
    end

    assign r0_ready      = ready_c[0];
    assign r1_ready      = ready_c[1];
    assign r0_resp_valid = resp_valid_q[0];
    assign r1_resp_valid = resp_valid_q[1];
    assign r0_result     = result_q[0];
    assign r1_result     = result_q[1];
    assign r0_flag       = flag_q[0];
    assign r1_flag       = flag_q[1];
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_func      = alu_func_q;
    assign busy          = busy_q;

`ifdef ALU_ARB_STATS_EN
    logic [1:0][CNT_W-1:0] gnt_cnt_q;

    // Saturating accept counters, one per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_q <= '0;
        end else if (accept_c && (gnt_cnt_q[arb_pick] != {CNT_W{1'b1}})) begin
            gnt_cnt_q[arb_pick] <= gnt_cnt_q[arb_pick] + CNT_W'(1);
        end
    end

    assign gnt_cnt0 = gnt_cnt_q[0];
    assign gnt_cnt1 = gnt_cnt_q[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, response scoreboard, and hand-written corner sequences.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] vld, rdy, rv, rr, flg;
    logic [7:0] ra[2], rb[2], res[2];
    logic [2:0] rf[2];
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_func;
    logic       alu_cout, busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    typedef struct {
        int         req;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] f;
        logic [7:0] er;
        logic       ef;
    } vec_t;

    typedef struct {
        int         req;
        logic [7:0] er;
        logic       ef;
    } exp_t;

    vec_t vt[10];
    exp_t sb[$];
    int   glog[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    alu_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .r0_valid      (vld[0]),
        .r0_ready      (rdy[0]),
        .r0_a          (ra[0]),
        .r0_b          (rb[0]),
        .r0_func       (rf[0]),
        .r0_resp_valid (rv[0]),
        .r0_resp_ready (rr[0]),
        .r0_result     (res[0]),
        .r0_flag       (flg[0]),
        .r1_valid      (vld[1]),
        .r1_ready      (rdy[1]),
        .r1_a          (ra[1]),
        .r1_b          (rb[1]),
        .r1_func       (rf[1]),
        .r1_resp_valid (rv[1]),
        .r1_resp_ready (rr[1]),
        .r1_result     (res[1]),
        .r1_flag       (flg[1]),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_func      (alu_func),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout),
`ifdef ALU_ARB_STATS_EN
        .busy          (busy),
        .gnt_cnt0      (gnt_cnt0),
        .gnt_cnt1      (gnt_cnt1)
`else
        .busy          (busy)
`endif
    );

    // External ALU model: add/sub with carry/borrow, opaque codes xor with cout stuck at 1.
    always_comb begin
        case (alu_func)
            3'd0:    {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    begin alu_result = alu_a - alu_b; alu_cout = (alu_a < alu_b); end
            default: begin alu_result = alu_a ^ alu_b; alu_cout = 1'b1; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic set_req(input int r, input logic v, input int vi);
        vld[r] = v;
        ra[r]  = vt[vi].a;
        rb[r]  = vt[vi].b;
        rf[r]  = vt[vi].f;
    endtask

    task automatic push_exp(input int vi);
        exp_t e;
        e.req = vt[vi].req;
        e.er  = vt[vi].er;
        e.ef  = vt[vi].ef;
        sb.push_back(e);
    endtask

    // Called at a negedge with valid already driven; returns at negedge+1 of the accept cycle.
    task automatic wait_ready(input int r, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rdy[r]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now($sformatf("ready_timeout_r%0d", r));
    endtask

    task automatic run_drv(input int r, input int vi, input int n);
        bit ok;
        for (int k = 0; k < n; k++) begin
            set_req(r, 1'b1, vi);
            wait_ready(r, ok);
            if (ok) begin
                push_exp(vi);
                glog.push_back(r);
            end
            @(negedge clk);
        end
        set_req(r, 1'b0, vi);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now("drain_timeout");
    endtask

    // Response monitor: every resp handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                for (int r = 0; r < 2; r++) begin
                    if (rv[r] && rr[r]) begin
                        if (sb.size() == 0) begin
                            fail_now($sformatf("unexpected_resp_r%0d", r));
                        end else begin
                            e = sb.pop_front();
                            check($sformatf("resp_owner_r%0d", r), 32'(r), 32'(e.req));
                            check($sformatf("result_r%0d", r), 32'(res[r]), 32'(e.er));
                            check($sformatf("flag_r%0d", r), 32'(flg[r]), 32'(e.ef));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int r;
        vt[0] = '{0, 8'd75,  8'd61,  3'd0, 8'd136, 1'b0};
        vt[1] = '{1, 8'd61,  8'd75,  3'd1, 8'd242, 1'b1};
        vt[2] = '{0, 8'd200, 8'd100, 3'd0, 8'd44,  1'b1};
        vt[3] = '{1, 8'd255, 8'd1,   3'd0, 8'd0,   1'b1};
        vt[4] = '{0, 8'd0,   8'd1,   3'd1, 8'd255, 1'b1};
        vt[5] = '{1, 8'd5,   8'd5,   3'd1, 8'd0,   1'b0};
        vt[6] = '{0, 8'd75,  8'd61,  3'd5, 8'd118, 1'b0};
        vt[7] = '{1, 8'd240, 8'd15,  3'd7, 8'd255, 1'b0};
        vt[8] = '{0, 8'd75,  8'd61,  3'd0, 8'd136, 1'b0};
        vt[9] = '{1, 8'd75,  8'd61,  3'd1, 8'd14,  1'b0};

        rst_n = 1'b0;
        vld = 2'b00;
        rr  = 2'b11;
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0; rb[i] = '0; rf[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_resp_valid", 32'(rv), 0);
        check("rst_ready", 32'(rdy), 0);
        check("rst_results", 32'({res[1], res[0]}), 0);
        check("rst_flags", 32'(flg), 0);
        check("rst_alu_ops", 32'({alu_func, alu_b, alu_a}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-requester vectors with latency checks
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r = vt[i].req;
            set_req(r, 1'b1, i);
            wait_ready(r, ok);
            if (ok) begin
                push_exp(i);
                check("other_ready_low", 32'(rdy[1-r]), 0);
            end
            @(negedge clk);
            set_req(r, 1'b0, i);
            #1;
            check("busy_exec", 32'(busy), 1);
            check("resp_not_yet", 32'(rv[r]), 0);
            check("alu_ops", 32'({alu_func, alu_b, alu_a}), 32'({vt[i].f, vt[i].b, vt[i].a}));
            @(negedge clk);
            #1;
            check("resp_latency", 32'(rv[r]), 1);
            check("other_chan_idle", 32'(rv[1-r]), 0);
            @(negedge clk);
            #1;
            check("busy_after", 32'(busy), 0);
            check("alu_ops_held", 32'({alu_func, alu_b, alu_a}), 32'({vt[i].f, vt[i].b, vt[i].a}));
        end
        drain();

        // Round-robin fairness from reset, both requesters always valid
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        glog.delete();
        fork
            run_drv(0, 8, 3);
            run_drv(1, 9, 3);
        join
        drain();
        check("grant_count", 32'(glog.size()), 6);
        for (int k = 0; k < glog.size(); k++) begin
            check($sformatf("grant_order_%0d", k), 32'(glog[k]), 32'(k % 2));
        end
`ifdef ALU_ARB_STATS_EN
        check("gnt_cnt0", 32'(gnt_cnt0), 3);
        check("gnt_cnt1", 32'(gnt_cnt1), 3);
`endif

        // Backpressure: r0 response held while r1 waits
        @(negedge clk);
        rr[0] = 1'b0;
        set_req(0, 1'b1, 0);
        wait_ready(0, ok);
        if (ok) push_exp(0);
        @(negedge clk);
        set_req(0, 1'b0, 0);
        set_req(1, 1'b1, 9);
        #1;
        check("bp_r1_blocked_exec", 32'(rdy[1]), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("bp_resp_valid", 32'(rv[0]), 1);
            check("bp_result_held", 32'(res[0]), 136);
            check("bp_r1_blocked", 32'(rdy[1]), 0);
            check("bp_busy", 32'(busy), 1);
        end
        @(negedge clk);
        rr[0] = 1'b1;
        #1;
        check("bp_no_accept_in_hs", 32'(rdy[1]), 0);
        @(negedge clk);
        #1;
        check("bp_r1_accept_after_hs", 32'(rdy[1]), 1);
        if (rdy[1]) push_exp(9);
        @(negedge clk);
        set_req(1, 1'b0, 9);
        drain();

        // Reset during EXEC discards the operation
        @(negedge clk);
        set_req(0, 1'b1, 2);
        wait_ready(0, ok);
        @(negedge clk);
        set_req(0, 1'b0, 2);
        #1;
        check("mid_exec_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_resp_valid", 32'(rv), 0);
        check("mid_rst_alu_ops", 32'({alu_func, alu_b, alu_a}), 0);
        check("mid_rst_results", 32'({flg, res[1], res[0]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_no_resp", 32'(rv), 0);
        end
        check("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one external 8-bit ALU instance (operands a/b, 3-bit func, result, Cout/borrow) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A round-robin arbiter picks one requester. The FSM registers that requester's operands onto the ALU, captures the result one cycle later and holds it until the owner takes it.
- Sits between the datapath front-ends and the shared ALU. One operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width.
- FUNC_W, 3, ALU function-code width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- r0_valid  in  1  requester 0 request valid.
- r0_ready  out  1  requester 0 request accepted this cycle.
- r0_a, r0_b  in  WIDTH  requester 0 operands.
- r0_func  in  FUNC_W  requester 0 function code.
- r0_resp_valid  out  1  requester 0 result valid.
- r0_resp_ready  in  1  requester 0 takes the result.
- r0_result  out  WIDTH  requester 0 result.
- r0_flag  out  1  requester 0 carry/borrow flag.
- r1_*  same set as r0_*, for requester 1.
- alu_a, alu_b  out  WIDTH  registered operands to the shared ALU.
- alu_func  out  FUNC_W  registered function code to the ALU.
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_func).
- alu_cout  in  1  ALU carry-out (func 0) / borrow-out (func 1).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, last_grant=1, so r0 wins the first tie.
  - All outputs 0, including alu_a/alu_b/alu_func and both resp_valid.
  - An in-flight operation is discarded; no response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - pick = the valid requester. If both are valid, pick the one that is not last_grant.
  - r<pick>_ready = 1 combinationally; the other ready = 0. With no valid request, both ready = 0.
  - Ready depends on valid; requesters must not make valid depend on ready.
  - On accept: alu_a/alu_b/alu_func <= the picked operands; owner <= pick; state -> EXEC.
- EXEC (exactly 1 cycle, ALU settles):
  - r<owner>_result <= alu_result.
  - r<owner>_flag <= alu_cout if func is 0 or 1, else 0.
  - r<owner>_resp_valid <= 1; last_grant <= owner; state -> RESP.
- RESP:
  - Result and flag are held stable while resp_valid=1.
  - When r<owner>_resp_ready=1: resp_valid <= 0, state -> IDLE.
  - No new request is accepted in the same cycle.
- Latency and throughput:
  - Request accepted at edge T; resp_valid high from T+2.
  - Minimum 3 cycles per operation.
- alu_a/alu_b/alu_func hold their last values after the operation; they are not cleared.
- A requester's valid/operands/func must stay stable until its ready is seen. A requester that drops valid before ready is simply not served.
- resp_ready on the non-owner channel is ignored.
- A resp_ready held high in advance gives a resp handshake in the first RESP cycle.
- Widths: result is WIDTH bits. Carry/borrow comes only from alu_cout; the block itself does no arithmetic.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds output ports gnt_cnt0 and gnt_cnt1, each 16 bits, reset to 0.
  - The owner's counter increments on every accept and saturates at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Function codes: FUNC_ADD=3'd0 and FUNC_SUB=3'd1; codes 2–7 are passed through opaque.
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - Defaults for WIDTH and FUNC_W.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: valid[1:0], last_grant.
  - Outputs: grant one-hot, pick index.

Test Plan:
- Reset: hold rst_n low for 3 cycles, then assert it low again mid-EXEC -> all outputs 0, busy=0, no resp_valid afterwards.
- r0 alone, a=75, b=61, func=0, accepted at T -> r0_resp_valid at T+2, r0_result=136, r0_flag=0.
- r1 alone, a=61, b=75, func=1 -> r1_result=242, r1_flag=1; r0 channel stays idle.
- Both valid from reset, each with 3 queued ops (r0: 75+61; r1: 75-61) -> grant order r0, r1, r0, r1, r0, r1; r1_result=14, r1_flag=0.
- Backpressure: r0 result pending with r0_resp_ready low for 5 cycles while r1_valid=1 -> r0_result held, r1_ready=0, busy=1; r1 accepted 1 cycle after the r0 resp handshake.
- r0 func=5 with alu_cout forced to 1 -> r0_flag=0.
- With ALU_ARB_STATS_EN, the previous 6-op run -> gnt_cnt0=3, gnt_cnt1=3.
